// File: rtl/vx_csa_accum.sv
// Streaming multi-operand accumulator: each beat is folded into a carry-save
// (sum, carry) pair; one carry-propagate add resolves the total per packet.
module vx_csa_accum #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [N*W-1:0]   data_in,
    input  logic             last_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [ACC_W-1:0] data_out,
    output logic [CNT_W-1:0] beats_out
);

    localparam int M = N + 2;

    // state    | meaning
    // ST_ACCUM  | accepting beats, folding into carry-save state
    // ST_RESOLVE| single CPA of sum+carry into data_out, clear state
    // ST_HOLD   | result presented, waiting for ready_out
    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [ACC_W-1:0] carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_in_q, ready_in_d;
    logic             valid_out_q, valid_out_d;
    logic [ACC_W-1:0] data_out_q, data_out_d;
    logic [CNT_W-1:0] beats_out_q, beats_out_d;

    logic [ACC_W-1:0] red_sum;
    logic [ACC_W-1:0] red_carry;

    // Wallace-style reduction: each level groups operands in threes through
    // 3:2 compressors until only two vectors remain; leftovers pass through.
    always_comb begin : reduce_tree
        logic [ACC_W-1:0] cur [M];
        logic [ACC_W-1:0] nxt [M];
        logic [ACC_W-1:0] op_a;
        logic [ACC_W-1:0] op_b;
        logic [ACC_W-1:0] op_c;
        int               cnt;
        int               grp;
        int               rem;

        for (int i = 0; i < N; i++) begin
            cur[i] = ACC_W'(data_in[i*W +: W]);
        end
        cur[N]   = sum_q;
        cur[N+1] = carry_q;
        cnt      = M;
        grp      = 0;
        rem      = 0;
        op_a     = '0;
        op_b     = '0;
        op_c     = '0;

        for (int lvl = 0; lvl < M; lvl++) begin
            nxt = cur;
            if (cnt > 2) begin
                grp = cnt / 3;
                rem = cnt - 3 * grp;
                for (int g = 0; g < M / 3; g++) begin
                    if (g < grp) begin
                        op_a       = cur[3*g];
                        op_b       = cur[3*g+1];
                        op_c       = cur[3*g+2];
                        nxt[2*g]   = op_a ^ op_b ^ op_c;
                        nxt[2*g+1] = ((op_a & op_b) | (op_a & op_c) | (op_b & op_c)) << 1;
                    end
                end
                for (int r = 0; r < 2; r++) begin
                    if (r < rem) begin
                        nxt[2*grp+r] = cur[3*grp+r];
                    end
                end
                cnt = 2 * grp + rem;
            end
            cur = nxt;
        end

        red_sum   = cur[0];
        red_carry = cur[1];
    end

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        ready_in_d  = ready_in_q;
        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;
        beats_out_d = beats_out_q;

        case (state_q)
            ST_ACCUM: begin
                if (valid_in && ready_in_q) begin
                    sum_d   = red_sum;
                    carry_d = red_carry;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (last_in) begin
                        state_d    = ST_RESOLVE;
                        ready_in_d = 1'b0;
                    end
                end
            end
            ST_RESOLVE: begin
                data_out_d  = sum_q + carry_q;
                beats_out_d = cnt_q;
                valid_out_d = 1'b1;
                sum_d       = '0;
                carry_d     = '0;
                cnt_d       = '0;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (ready_out) begin
                    valid_out_d = 1'b0;
                    ready_in_d  = 1'b1;
                    state_d     = ST_ACCUM;
                end
            end
            default: begin
                state_d     = ST_ACCUM;
                ready_in_d  = 1'b1;
                valid_out_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ACCUM;
            sum_q       <= '0;
            carry_q     <= '0;
            cnt_q       <= '0;
            ready_in_q  <= 1'b1;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            beats_out_q <= '0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            ready_in_q  <= ready_in_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            beats_out_q <= beats_out_d;
        end
    end

    assign ready_in  = ready_in_q;
    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign beats_out = beats_out_q;

endmodule

// File: tb/tb_vx_csa_accum.sv
// Bench for vx_csa_accum: directed scenarios plus randomized packets scored
// against a plain-arithmetic packet total. A 10-bit instance checks wrapping.
module tb_vx_csa_accum;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int ACC_W = 24;
    localparam int ACC_S = 10;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             valid_in;
    logic [N*W-1:0]   data_in;
    logic             last_in;
    logic             ready_out;

    logic             ready_in, valid_out;
    logic [ACC_W-1:0] data_out;
    logic [CNT_W-1:0] beats_out;
    logic             ready_in_s, valid_out_s;
    logic [ACC_S-1:0] data_out_s;
    logic [CNT_W-1:0] beats_out_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vx_csa_accum #(.N(N), .W(W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .data_in(data_in), .last_in(last_in), .valid_out(valid_out),
        .ready_out(ready_out), .data_out(data_out), .beats_out(beats_out)
    );

    vx_csa_accum #(.N(N), .W(W), .ACC_W(ACC_S), .CNT_W(CNT_W)) dut_s (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in_s),
        .data_in(data_in), .last_in(last_in), .valid_out(valid_out_s),
        .ready_out(ready_out), .data_out(data_out_s), .beats_out(beats_out_s)
    );

    function automatic logic [N*W-1:0] pack(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic longint beat_sum(input logic [N*W-1:0] d);
        longint s = 0;
        for (int i = 0; i < N; i++) s += longint'(d[i*W +: W]);
        return s;
    endfunction

    // Present a beat and hold it until the DUT takes it; returns at #1 after the accepting edge.
    task automatic send_beat(input logic [N*W-1:0] d, input logic last, output bit to);
        int guard = 0;
        valid_in = 1'b1;
        data_in  = d;
        last_in  = last;
        while (!ready_in && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        to = !ready_in;
        @(posedge clk); #1;
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output bit to);
        lat = 0;
        while (!valid_out && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        to = !valid_out;
    endtask

    task automatic test_reset;
        reset = 1'b1; valid_in = 1'b0; last_in = 1'b0; data_in = '0; ready_out = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %0b want 0", valid_out); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data_out: got %0d want 0", data_out); end
        checks++; if (beats_out !== '0) begin errors++; $display("FAIL reset_beats_out: got %0d want 0", beats_out); end
        checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL reset_ready_in: got %0b want 1", ready_in); end
    endtask

    task automatic test_single_beat;
        bit to;
        send_beat(pack(1, 2, 3, 4), 1'b1, to);
        checks++; if (to) begin errors++; $display("FAIL single_accept: timeout got 1 want 0"); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL single_t1_valid: got %0b want 0", valid_out); end
        checks++; if (ready_in !== 1'b0) begin errors++; $display("FAIL single_t1_ready_in: got %0b want 0", ready_in); end
        @(posedge clk); #1;
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL single_t2_valid: got %0b want 1", valid_out); end
        checks++; if (data_out !== 24'd10) begin errors++; $display("FAIL single_data: got %0d want 10", data_out); end
        checks++; if (beats_out !== 8'd1) begin errors++; $display("FAIL single_beats: got %0d want 1", beats_out); end
        @(posedge clk); #1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL single_t3_valid: got %0b want 0", valid_out); end
        checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL single_t3_ready_in: got %0b want 1", ready_in); end
    endtask

    task automatic test_multi_beat;
        bit to; int lat;
        for (int b = 0; b < 3; b++) send_beat(pack(255, 255, 255, 255), b == 2, to);
        wait_valid(lat, to);
        checks++; if (lat !== 1) begin errors++; $display("FAIL multi_latency: got %0d want 1", lat); end
        checks++; if (data_out !== 24'd3060) begin errors++; $display("FAIL multi_data: got %0d want 3060", data_out); end
        checks++; if (beats_out !== 8'd3) begin errors++; $display("FAIL multi_beats: got %0d want 3", beats_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall;
        bit to; int lat;
        ready_out = 1'b0;
        send_beat(pack(1, 2, 3, 4), 1'b1, to);
        wait_valid(lat, to);
        checks++; if (to) begin errors++; $display("FAIL stall_valid: timeout got 1 want 0"); end
        // Next packet's beat waits on the input while the result is held.
        valid_in = 1'b1; data_in = pack(5, 5, 5, 5); last_in = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL stall_hold_valid[%0d]: got %0b want 1", c, valid_out); end
            checks++; if (data_out !== 24'd10) begin errors++; $display("FAIL stall_hold_data[%0d]: got %0d want 10", c, data_out); end
            checks++; if (ready_in !== 1'b0) begin errors++; $display("FAIL stall_hold_ready_in[%0d]: got %0b want 0", c, ready_in); end
            @(posedge clk); #1;
        end
        ready_out = 1'b1;
        @(posedge clk); #1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL stall_release_valid: got %0b want 0", valid_out); end
        checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL stall_release_ready_in: got %0b want 1", ready_in); end
        send_beat(pack(5, 5, 5, 5), 1'b1, to);
        wait_valid(lat, to);
        checks++; if (data_out !== 24'd20) begin errors++; $display("FAIL stall_next_data: got %0d want 20", data_out); end
        checks++; if (beats_out !== 8'd1) begin errors++; $display("FAIL stall_next_beats: got %0d want 1", beats_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap;
        bit to; int lat;
        for (int b = 0; b < 2; b++) send_beat(pack(255, 255, 255, 255), b == 1, to);
        wait_valid(lat, to);
        checks++; if (data_out_s !== 10'd1016) begin errors++; $display("FAIL wrap_small_data: got %0d want 1016", data_out_s); end
        checks++; if (data_out !== 24'd2040) begin errors++; $display("FAIL wrap_wide_data: got %0d want 2040", data_out); end
        checks++; if (beats_out_s !== 8'd2) begin errors++; $display("FAIL wrap_beats: got %0d want 2", beats_out_s); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        bit to; int lat;
        for (int b = 0; b < 2; b++) send_beat(pack(9, 9, 9, 9), 1'b0, to);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0b want 0", valid_out); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL rstmid_data: got %0d want 0", data_out); end
        checks++; if (beats_out !== '0) begin errors++; $display("FAIL rstmid_beats: got %0d want 0", beats_out); end
        checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL rstmid_ready_in: got %0b want 1", ready_in); end
        send_beat(pack(1, 1, 1, 1), 1'b1, to);
        wait_valid(lat, to);
        checks++; if (data_out !== 24'd4) begin errors++; $display("FAIL rstmid_next_data: got %0d want 4", data_out); end
        checks++; if (beats_out !== 8'd1) begin errors++; $display("FAIL rstmid_next_beats: got %0d want 1", beats_out); end
        @(posedge clk); #1;
        // Reset while a result is held.
        ready_out = 1'b0;
        send_beat(pack(7, 7, 7, 7), 1'b1, to);
        wait_valid(lat, to);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; ready_out = 1'b1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rsthold_valid: got %0b want 0", valid_out); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL rsthold_data: got %0d want 0", data_out); end
    endtask

    task automatic test_saturate;
        bit to; int lat;
        for (int b = 0; b < 300; b++) send_beat(pack(1, 0, 0, 0), b == 299, to);
        wait_valid(lat, to);
        checks++; if (data_out !== 24'd300) begin errors++; $display("FAIL sat_data: got %0d want 300", data_out); end
        checks++; if (beats_out !== 8'd255) begin errors++; $display("FAIL sat_beats: got %0d want 255", beats_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        bit to; int lat; int len; int stall;
        longint total;
        logic [N*W-1:0] d;
        logic [ACC_W-1:0] exp_w;
        logic [ACC_S-1:0] exp_s;
        for (int p = 0; p < 30; p++) begin
            len = $urandom_range(1, 20);
            total = 0;
            ready_out = 1'b1;
            for (int b = 0; b < len; b++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom_range(0, 255));
                total += beat_sum(d);
                send_beat(d, b == len - 1, to);
                checks++; if (to) begin errors++; $display("FAIL rnd_accept[%0d]: timeout got 1 want 0", p); end
            end
            exp_w = ACC_W'(total % (longint'(1) << ACC_W));
            exp_s = ACC_S'(total % (longint'(1) << ACC_S));
            wait_valid(lat, to);
            checks++; if (lat !== 1) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d want 1", p, lat); end
            checks++; if (data_out !== exp_w) begin errors++; $display("FAIL rnd_data[%0d]: got %0d want %0d", p, data_out, exp_w); end
            checks++; if (data_out_s !== exp_s) begin errors++; $display("FAIL rnd_data_small[%0d]: got %0d want %0d", p, data_out_s, exp_s); end
            checks++; if (beats_out !== CNT_W'(len)) begin errors++; $display("FAIL rnd_beats[%0d]: got %0d want %0d", p, beats_out, len); end
            stall = $urandom_range(0, 3);
            ready_out = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                checks++; if (valid_out !== 1'b1 || data_out !== exp_w) begin
                    errors++; $display("FAIL rnd_stall[%0d]: got valid %0b data %0d want valid 1 data %0d", p, valid_out, data_out, exp_w);
                end
            end
            ready_out = 1'b1;
            @(posedge clk); #1;
            checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rnd_drop[%0d]: got %0b want 0", p, valid_out); end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
